// File: rtl/mole_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mole_pkg
// Brief    : Shared types and constants for the Whac-A-Mole round scheduler.
// Revision : 1.0
// ============================================================================
package mole_pkg;

    localparam int NUM_HOLES = 18;
    localparam int NUM_MOLES = 3;
    localparam int POINT_CAP = 4;
    localparam int POS_W     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_e;

    typedef logic [POS_W-1:0]     pos_t;
    typedef logic [NUM_HOLES-1:0] hole_mask_t;

    // Positions beyond the hole range shift out and yield an empty mask.
    function automatic hole_mask_t pos_to_bit(input pos_t p);
        return hole_mask_t'(1) << p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mole_round_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : mole_round_scheduler_if
// Brief    : Game inputs, generator handshake and display outputs of the scheduler.
// Revision : 1.0
// ============================================================================
interface mole_round_scheduler_if
    import mole_pkg::*;
#(
    parameter int SCORE_W = 10,
    parameter int COMBO_W = 4
);
    logic               tick;
    logic               start;
    hole_mask_t         sw;
    logic               gen_req;
    logic               gen_valid;
    pos_t               gen_pos;
    hole_mask_t         mole_mask;
    logic [SCORE_W-1:0] score;
    logic [COMBO_W-1:0] combo_count;
    logic [15:0]        time_left;
    logic               game_active;
    logic               game_over;

    modport master (
        output tick, start, sw, gen_valid, gen_pos,
        input  gen_req, mole_mask, score, combo_count, time_left, game_active, game_over
    );

    modport slave (
        input  tick, start, sw, gen_valid, gen_pos,
        output gen_req, mole_mask, score, combo_count, time_left, game_active, game_over
    );
endinterface
`default_nettype wire

// File: rtl/mole_slot_timer.sv
`default_nettype none
// ============================================================================
// Module   : mole_slot_timer
// Brief    : One mole slot: holds a hole index and ages it down to expiry.
// Revision : 1.0
// ============================================================================
module mole_slot_timer
    import mole_pkg::*;
#(
    parameter int MOLE_LIFE = 1500
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  pos_t pos_i,
    input  logic tick_i,
    input  logic kill_i,
    output logic busy_o,
    output pos_t pos_o,
    output logic expire_o
);
    localparam int LIFE_W = $clog2(MOLE_LIFE + 1);

    logic [LIFE_W-1:0] life_q;
    logic              busy_q;
    pos_t              pos_q;

    // Raw timeout; the parent decides whether a same-cycle hit overrides it.
    assign expire_o = busy_q && tick_i && (life_q == LIFE_W'(1));
    assign busy_o   = busy_q;
    assign pos_o    = pos_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            life_q <= '0;
            pos_q  <= '0;
        end else if (kill_i) begin
            busy_q <= 1'b0;
            life_q <= '0;
        end else if (load_i) begin
            busy_q <= 1'b1;
            life_q <= LIFE_W'(MOLE_LIFE);
            pos_q  <= pos_i;
        end else if (busy_q && tick_i) begin
            life_q <= life_q - 1'b1;
            if (expire_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mole_round_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mole_round_scheduler
// Brief    : Sequences one timed Whac-A-Mole round: spawning, ageing, scoring.
// Revision : 1.0
// ============================================================================
module mole_round_scheduler
    import mole_pkg::*;
#(
    parameter int MOLE_LIFE  = 1500,
    parameter int SPAWN_GAP  = 500,
    parameter int GAME_TICKS = 60000,
    parameter int SCORE_W    = 10,
    parameter int COMBO_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mole_round_scheduler_if.slave bus
);
    localparam int                 SPAWN_W      = $clog2(SPAWN_GAP + 1);
    localparam logic [SPAWN_W-1:0] C_SPAWN_FULL = SPAWN_W'(SPAWN_GAP);

    state_e             state_q, state_d;
    logic [15:0]        time_q, time_d;
    logic [SPAWN_W-1:0] spawn_q, spawn_d;
    logic               gen_req_q, gen_req_d;
    hole_mask_t         mask_q, mask_d, sw_prev_q;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic               active_q, over_q;

    logic [NUM_MOLES-1:0] w_busy, w_expire, w_kill, w_load, w_miss, w_busy_next, w_hit_slot;
    pos_t                 w_slot_pos [NUM_MOLES];
    hole_mask_t           w_edge;
    pos_t                 w_edge_idx;
    logic                 w_edge_any, w_run, w_hit, w_wrong, w_accept;
    logic                 w_start_go, w_round_end, w_clear, w_free_taken;
    logic [COMBO_W-1:0]   w_combo_hit;
    logic [SCORE_W-1:0]   w_points;
    logic [SCORE_W:0]     w_score_sum;

    for (genvar g = 0; g < NUM_MOLES; g++) begin : g_slot
        mole_slot_timer #(.MOLE_LIFE(MOLE_LIFE)) u_slot (
            .clk      (clk),
            .reset    (reset),
            .load_i   (w_load[g]),
            .pos_i    (bus.gen_pos),
            .tick_i   (bus.tick),
            .kill_i   (w_kill[g]),
            .busy_o   (w_busy[g]),
            .pos_o    (w_slot_pos[g]),
            .expire_o (w_expire[g])
        );
    end

    always_comb begin
        w_run      = (state_q == RUN);
        w_edge     = bus.sw ^ sw_prev_q;
        w_edge_any = 1'b0;
        w_edge_idx = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            if (w_edge[i] && !w_edge_any) begin
                w_edge_any = 1'b1;
                w_edge_idx = POS_W'(i);
            end
        end
        w_hit       = w_run && w_edge_any && ((mask_q & pos_to_bit(w_edge_idx)) != '0);
        w_wrong     = w_run && w_edge_any && !w_hit;
        // Occupancy check uses the start-of-cycle mask, so a hole freed now cannot be re-used now.
        w_accept    = w_run && gen_req_q && bus.gen_valid &&
                      (bus.gen_pos < POS_W'(NUM_HOLES)) &&
                      ((mask_q & pos_to_bit(bus.gen_pos)) == '0);
        w_start_go  = (state_q == IDLE || state_q == OVER) && bus.start;
        w_round_end = w_run && bus.tick && (time_q == 16'd1);
        w_clear     = w_start_go || w_round_end;

        w_hit_slot   = '0;
        w_kill       = '0;
        w_miss       = '0;
        w_load       = '0;
        w_busy_next  = '0;
        w_free_taken = 1'b0;
        for (int k = 0; k < NUM_MOLES; k++) begin
            w_hit_slot[k] = w_hit && w_busy[k] && (w_slot_pos[k] == w_edge_idx);
            w_kill[k]     = w_clear || w_hit_slot[k];
            w_miss[k]     = w_expire[k] && !w_hit_slot[k];
            if (!w_busy[k] && !w_free_taken) begin
                w_load[k]    = w_accept;
                w_free_taken = 1'b1;
            end
            w_busy_next[k] = !w_clear &&
                             (w_load[k] || (w_busy[k] && !w_hit_slot[k] && !w_expire[k]));
        end
    end

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        spawn_d = spawn_q;
        mask_d  = mask_q;
        score_d = score_q;
        combo_d = combo_q;

        w_combo_hit = (combo_q == '1) ? combo_q : combo_q + 1'b1;
        w_points    = (int'(w_combo_hit) > POINT_CAP) ? SCORE_W'(POINT_CAP) : SCORE_W'(w_combo_hit);
        w_score_sum = {1'b0, score_q} + {1'b0, w_points};

        case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    state_d = RUN;
                    time_d  = 16'(GAME_TICKS);
                    spawn_d = C_SPAWN_FULL;
                    mask_d  = '0;
                    score_d = '0;
                    combo_d = '0;
                end
            end
            RUN: begin
                if (w_accept) begin
                    spawn_d = '0;
                    mask_d  = mask_d | pos_to_bit(bus.gen_pos);
                end else if (bus.tick && spawn_q != C_SPAWN_FULL) begin
                    spawn_d = spawn_q + 1'b1;
                end
                if (w_hit) begin
                    mask_d  = mask_d & ~pos_to_bit(w_edge_idx);
                    combo_d = w_combo_hit;
                    score_d = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
                end else if (w_wrong) begin
                    combo_d = '0;
                end
                // A miss on another slot lands after the hit, so combo ends at zero.
                for (int k = 0; k < NUM_MOLES; k++) begin
                    if (w_miss[k]) begin
                        mask_d  = mask_d & ~pos_to_bit(w_slot_pos[k]);
                        combo_d = '0;
                    end
                end
                if (bus.tick) begin
                    time_d = time_q - 16'd1;
                    if (w_round_end) begin
                        state_d = OVER;
                        mask_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        gen_req_d = (state_d == RUN) && (spawn_d == C_SPAWN_FULL) && (w_busy_next != '1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            time_q    <= '0;
            spawn_q   <= '0;
            gen_req_q <= 1'b0;
            mask_q    <= '0;
            sw_prev_q <= '0;
            score_q   <= '0;
            combo_q   <= '0;
            active_q  <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            spawn_q   <= spawn_d;
            gen_req_q <= gen_req_d;
            mask_q    <= mask_d;
            sw_prev_q <= bus.sw;
            score_q   <= score_d;
            combo_q   <= combo_d;
            active_q  <= (state_d == RUN);
            over_q    <= (state_d == OVER);
        end
    end

    assign bus.gen_req     = gen_req_q;
    assign bus.mole_mask   = mask_q;
    assign bus.score       = score_q;
    assign bus.combo_count = combo_q;
    assign bus.time_left   = time_q;
    assign bus.game_active = active_q;
    assign bus.game_over   = over_q;

endmodule
`default_nettype wire

// File: tb/tb_mole_round_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mole_round_scheduler
// Brief    : Directed and random stimulus against a queue-based round model.
// Revision : 1.0
// ============================================================================
module tb_mole_round_scheduler;
    import mole_pkg::*;

    localparam int LIFE = 30;
    localparam int GAP  = 5;
    localparam int GAME = 400;
    localparam int SW_W = 6;
    localparam int CW   = 3;
    localparam int SMAX = (1 << SW_W) - 1;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mole_round_scheduler_if #(.SCORE_W(SW_W), .COMBO_W(CW)) bus ();

    mole_round_scheduler #(
        .MOLE_LIFE (LIFE),
        .SPAWN_GAP (GAP),
        .GAME_TICKS(GAME),
        .SCORE_W   (SW_W),
        .COMBO_W   (CW)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [17:0] sw_lvl = '0;

    // Round model: moles are an unordered list of (hole, ticks left).
    typedef struct { int hole; int life; } mole_t;
    mole_t       m_moles[$];
    int          m_state, m_time, m_spawn, m_score, m_combo;
    bit          m_req;
    logic [17:0] m_swprev;

    function automatic int find_mole(input int h);
        foreach (m_moles[j]) if (m_moles[j].hole == h) return j;
        return -1;
    endfunction

    function automatic logic [17:0] m_mask();
        logic [17:0] m = '0;
        foreach (m_moles[j]) m[m_moles[j].hole] = 1'b1;
        return m;
    endfunction

    task automatic model_step(input bit rs, input bit tk, input bit st,
                              input logic [17:0] s, input bit gv, input int gp);
        logic [17:0] edges;
        int first, j, pts;
        bit acc;
        if (rs) begin
            m_moles.delete();
            m_state = 0; m_time = 0; m_spawn = 0; m_score = 0; m_combo = 0;
            m_req = 1'b0; m_swprev = '0;
            return;
        end
        edges = s ^ m_swprev;
        m_swprev = s;
        if (m_state != 1) begin
            if (st) begin
                m_state = 1; m_time = GAME; m_spawn = GAP;
                m_moles.delete(); m_score = 0; m_combo = 0;
            end
        end else begin
            acc = m_req && gv && (gp < NUM_HOLES) && (find_mole(gp) < 0);
            first = -1;
            for (int i = 0; i < NUM_HOLES; i++) if (edges[i]) begin first = i; break; end
            if (first >= 0) begin
                j = find_mole(first);
                if (j >= 0) begin
                    m_moles.delete(j);
                    m_combo = (m_combo + 1 > CMAX) ? CMAX : m_combo + 1;
                    pts = (m_combo > POINT_CAP) ? POINT_CAP : m_combo;
                    m_score = (m_score + pts > SMAX) ? SMAX : m_score + pts;
                end else begin
                    m_combo = 0;
                end
            end
            if (tk) begin
                for (int k = m_moles.size() - 1; k >= 0; k--) begin
                    m_moles[k].life--;
                    if (m_moles[k].life == 0) begin
                        m_moles.delete(k);
                        m_combo = 0;
                    end
                end
            end
            if (acc) begin
                m_moles.push_back('{hole: gp, life: LIFE});
                m_spawn = 0;
            end else if (tk && m_spawn < GAP) begin
                m_spawn++;
            end
            if (tk) begin
                m_time--;
                if (m_time == 0) begin
                    m_state = 2;
                    m_moles.delete();
                end
            end
        end
        m_req = (m_state == 1) && (m_spawn == GAP) && (m_moles.size() < NUM_MOLES);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL cyc=%0d %s got=%0h exp=%0h", cyc, name, got, exp);
        end
    endtask

    task automatic compare_model();
        chk("mole_mask",   32'(bus.mole_mask),   32'(m_mask()));
        chk("score",       32'(bus.score),       m_score);
        chk("combo_count", 32'(bus.combo_count), m_combo);
        chk("time_left",   32'(bus.time_left),   m_time);
        chk("gen_req",     32'(bus.gen_req),     32'(m_req));
        chk("game_active", 32'(bus.game_active), 32'(m_state == 1));
        chk("game_over",   32'(bus.game_over),   32'(m_state == 2));
    endtask

    task automatic step(input bit rs, input bit tk, input bit st, input bit gv, input int gp);
        rst           = rs;
        bus.tick      = tk;
        bus.start     = st;
        bus.sw        = sw_lvl;
        bus.gen_valid = gv;
        bus.gen_pos   = 5'(gp);
        model_step(rs, tk, st, sw_lvl, gv, gp);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        compare_model();
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0);
    endtask

    task automatic offer(input int gp);
        step(0, 0, 0, 1, gp);
    endtask

    task automatic toggle(input logic [17:0] bits);
        sw_lvl ^= bits;
        step(0, 0, 0, 0, 0);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 60 && !m_req; i++) step(0, 1, 0, 0, 0);
        chk("req_ready", 32'(bus.gen_req), 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mask"},   32'(bus.mole_mask),   0);
        chk({tag, "_score"},  32'(bus.score),       0);
        chk({tag, "_combo"},  32'(bus.combo_count), 0);
        chk({tag, "_time"},   32'(bus.time_left),   0);
        chk({tag, "_req"},    32'(bus.gen_req),     0);
        chk({tag, "_active"}, 32'(bus.game_active), 0);
        chk({tag, "_over"},   32'(bus.game_over),   0);
    endtask

    bit r_rs, r_tk, r_st, r_gv;
    int r_gp;

    initial begin
        bus.tick = 1'b0; bus.start = 1'b0; bus.sw = '0; bus.gen_valid = 1'b0; bus.gen_pos = '0;
        @(negedge clk);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check_all_zero("reset");

        // First spawn and scoring sequence.
        step(0, 0, 1, 0, 0);
        chk("start_req",    32'(bus.gen_req),     1);
        chk("start_active", 32'(bus.game_active), 1);
        chk("start_time",   32'(bus.time_left),   GAME);
        offer(4);
        chk("spawn4_mask", 32'(bus.mole_mask), 32'h10);
        chk("spawn4_req",  32'(bus.gen_req),   0);
        toggle(18'(1) << 4);
        chk("hit4_score", 32'(bus.score),       1);
        chk("hit4_combo", 32'(bus.combo_count), 1);
        chk("hit4_mask",  32'(bus.mole_mask),   0);
        wait_req();
        offer(9);
        toggle(18'(1) << 9);
        chk("hit9_score", 32'(bus.score),       3);
        chk("hit9_combo", 32'(bus.combo_count), 2);

        // Rejected proposals keep the request up.
        wait_req();
        offer(5);
        wait_req();
        offer(5);
        chk("rej_dup_req", 32'(bus.gen_req), 1);
        offer(20);
        chk("rej_range_req", 32'(bus.gen_req), 1);
        offer(14);
        chk("acc14_mask", 32'(bus.mole_mask), 32'h4020);
        chk("acc14_req",  32'(bus.gen_req),   0);
        toggle(18'(1) << 5);
        toggle(18'(1) << 14);
        chk("hit14_score", 32'(bus.score),       10);
        chk("hit14_combo", 32'(bus.combo_count), 4);

        // Expiry lands exactly on the LIFE-th tick.
        wait_req();
        offer(3);
        tick_n(LIFE - 1);
        chk("pre_exp_mask",  32'(bus.mole_mask),   32'h8);
        chk("pre_exp_combo", 32'(bus.combo_count), 4);
        tick_n(1);
        chk("exp_mask",  32'(bus.mole_mask),   0);
        chk("exp_combo", 32'(bus.combo_count), 0);
        chk("exp_score", 32'(bus.score),       10);

        // Two edges at once: only the lowest hole counts.
        wait_req();
        offer(2);
        toggle((18'(1) << 2) | (18'(1) << 7));
        chk("dual_combo", 32'(bus.combo_count), 1);
        chk("dual_score", 32'(bus.score),       11);
        chk("dual_mask",  32'(bus.mole_mask),   0);

        for (int c = 0; c < 8000; c++) begin
            r_rs = ($urandom_range(0, 2999) == 0);
            r_tk = 1'($urandom_range(0, 1));
            r_st = ($urandom_range(0, 60) == 0);
            r_gv = ($urandom_range(0, 2) == 0);
            r_gp = $urandom_range(0, 23);
            if ($urandom_range(0, 3) == 0) begin
                if (m_moles.size() > 0 && $urandom_range(0, 1) == 1)
                    sw_lvl ^= 18'(1) << m_moles[$urandom_range(0, m_moles.size() - 1)].hole;
                else
                    sw_lvl ^= 18'(1) << $urandom_range(0, 17);
                if ($urandom_range(0, 7) == 0)
                    sw_lvl ^= 18'(1) << $urandom_range(0, 17);
            end
            step(r_rs, r_tk, r_st, r_gv, r_gp);
        end

        // Mid-round reset, then a full round to the end.
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        offer(4);
        tick_n(3);
        step(1, 0, 0, 0, 0);
        check_all_zero("midreset");
        step(0, 0, 1, 0, 0);
        offer(6);
        toggle(18'(1) << 6);
        chk("round_score", 32'(bus.score), 1);
        for (int i = 0; i < 1000 && m_state != 2; i++) step(0, 1, 0, 0, 0);
        chk("end_over",  32'(bus.game_over),   1);
        chk("end_mask",  32'(bus.mole_mask),   0);
        chk("end_req",   32'(bus.gen_req),     0);
        chk("end_time",  32'(bus.time_left),   0);
        chk("end_score", 32'(bus.score),       1);
        step(0, 0, 1, 0, 0);
        chk("restart_score",  32'(bus.score),       0);
        chk("restart_active", 32'(bus.game_active), 1);
        chk("restart_over",   32'(bus.game_over),   0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
